// File: rtl/mainfsm.sv
// Multicycle MIPS-style main control FSM with retired-instruction counter and sticky illegal flag.
// Optional BNE support is enabled by defining MAINFSM_BNE_EN.
`timescale 1ns/1ps
module mainfsm #(
  parameter int unsigned    OPW      = 6,
  parameter int unsigned    CNTW     = 16,
  parameter logic [OPW-1:0] OP_RTYPE = OPW'('h00),
  parameter logic [OPW-1:0] OP_LW    = OPW'('h23),
  parameter logic [OPW-1:0] OP_SW    = OPW'('h2B),
  parameter logic [OPW-1:0] OP_BEQ   = OPW'('h04),
  parameter logic [OPW-1:0] OP_BNE   = OPW'('h05),
  parameter logic [OPW-1:0] OP_ADDI  = OPW'('h08),
  parameter logic [OPW-1:0] OP_J     = OPW'('h02)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OPW-1:0]  op,
  input  logic            mem_ready,
  output logic            iord,
  output logic            irwrite,
  output logic            pcwrite,
  output logic            memwrite,
  output logic            regwrite,
  output logic            regdst,
  output logic            memtoreg,
  output logic            alusrca,
  output logic            branch,
  output logic            branchne,
  output logic [1:0]      alusrcb,
  output logic [1:0]      pcsrc,
  output logic [1:0]      aluop,
  output logic [3:0]      state,
  output logic            illegal,
  output logic [CNTW-1:0] instret
);

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExecute = 4'd6,
    StAluWb   = 4'd7,
    StBranch  = 4'd8,
    StAddiEx  = 4'd9,
    StAddiWb  = 4'd10,
    StJump    = 4'd11,
    StBnex    = 4'd12,
    StTrap    = 4'd15
  } state_e;

  state_e          state_q, state_d;
  logic            illegal_q, illegal_d;
  logic [CNTW-1:0] instret_q, instret_d;
  logic            retire;

  function automatic state_e decode_op(input logic [OPW-1:0] opc);
    state_e nxt;
    nxt = StTrap;
    if (opc == OP_LW || opc == OP_SW) nxt = StMemAdr;
    else if (opc == OP_RTYPE)         nxt = StExecute;
    else if (opc == OP_BEQ)           nxt = StBranch;
    else if (opc == OP_ADDI)          nxt = StAddiEx;
    else if (opc == OP_J)             nxt = StJump;
`ifdef MAINFSM_BNE_EN
    else if (opc == OP_BNE)           nxt = StBnex;
`else
    else if (opc == OP_BNE)           nxt = StTrap;
`endif
    return nxt;
  endfunction

  // State register and counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      instret_q <= instret_d;
    end
  end

  // Next-state logic; unused codes 13-14 recover to FETCH through the default arm.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:   if (mem_ready) state_d = StDecode;
      StDecode:  state_d = decode_op(op);
      StMemAdr:  state_d = (op == OP_SW) ? StMemWr : StMemRd;
      StMemRd:   if (mem_ready) state_d = StMemWb;
      StMemWb:   state_d = StFetch;
      StMemWr:   if (mem_ready) state_d = StFetch;
      StExecute: state_d = StAluWb;
      StAluWb:   state_d = StFetch;
      StBranch:  state_d = StFetch;
      StAddiEx:  state_d = StAddiWb;
      StAddiWb:  state_d = StFetch;
      StJump:    state_d = StFetch;
`ifdef MAINFSM_BNE_EN
      StBnex:    state_d = StFetch;
`endif
      StTrap:    state_d = StTrap;
      default:   state_d = StFetch;
    endcase
  end

  // An instruction retires on the edge that leaves its terminal state.
  always_comb begin
    retire = 1'b0;
    case (state_q)
      StMemWb, StAluWb, StBranch, StAddiWb, StJump: retire = 1'b1;
      StMemWr: retire = mem_ready;
`ifdef MAINFSM_BNE_EN
      StBnex:  retire = 1'b1;
`endif
      default: retire = 1'b0;
    endcase
  end

  always_comb begin
    instret_d = instret_q + {{(CNTW-1){1'b0}}, retire};
    illegal_d = illegal_q | (state_d == StTrap);
  end

  // Moore outputs; FETCH additionally gates its IR/PC writes with mem_ready.
  always_comb begin
    iord     = 1'b0;
    irwrite  = 1'b0;
    pcwrite  = 1'b0;
    memwrite = 1'b0;
    regwrite = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    alusrca  = 1'b0;
    branch   = 1'b0;
    branchne = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    aluop    = 2'b00;
    case (state_q)
      StFetch: begin
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcwrite = mem_ready;
      end
      StDecode: alusrcb = 2'b11;
      StMemAdr: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      StMemRd: iord = 1'b1;
      StMemWb: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      StMemWr: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      StExecute: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      StAluWb: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      StBranch: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      StAddiEx: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      StAddiWb: regwrite = 1'b1;
      StJump: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
`ifdef MAINFSM_BNE_EN
      StBnex: begin
        alusrca  = 1'b1;
        aluop    = 2'b01;
        pcsrc    = 2'b01;
        branchne = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign state   = state_q;
  assign illegal = illegal_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_mainfsm.sv
// Self-checking bench for mainfsm: directed instruction table, corner sequences and
// randomized instruction streams checked against an instruction-level path model.
`timescale 1ns/1ps
module tb_mainfsm;
  localparam int unsigned OPW  = 6;
  localparam int unsigned CNTW = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [OPW-1:0]  op = '0;
  logic            mem_ready = 1'b0;
  logic            iord, irwrite, pcwrite, memwrite, regwrite, regdst, memtoreg;
  logic            alusrca, branch, branchne, illegal;
  logic [1:0]      alusrcb, pcsrc, aluop;
  logic [3:0]      state;
  logic [CNTW-1:0] instret;

  mainfsm #(.OPW(OPW), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .iord(iord), .irwrite(irwrite), .pcwrite(pcwrite), .memwrite(memwrite),
    .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca),
    .branch(branch), .branchne(branchne), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .aluop(aluop), .state(state), .illegal(illegal), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       iord, irwrite, pcwrite, memwrite, regwrite, regdst, memtoreg;
    logic       alusrca, branch, branchne;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic       illegal;
  } ctrl_t;

  ctrl_t act;
  assign act = {iord, irwrite, pcwrite, memwrite, regwrite, regdst, memtoreg,
                alusrca, branch, branchne, alusrcb, pcsrc, aluop, illegal};

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  int mw_seen = 0;

  // Control word the specification lists for each state code.
  function automatic ctrl_t exp_ctrl(input logic [3:0] s, input logic mr);
    ctrl_t c;
    c = '0;
    case (s)
      4'd0:  begin c.alusrcb = 2'b01; c.irwrite = mr; c.pcwrite = mr; end
      4'd1:  c.alusrcb = 2'b11;
      4'd2:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      4'd3:  c.iord = 1'b1;
      4'd4:  begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
      4'd5:  begin c.iord = 1'b1; c.memwrite = 1'b1; end
      4'd6:  begin c.alusrca = 1'b1; c.aluop = 2'b10; end
      4'd7:  begin c.regdst = 1'b1; c.regwrite = 1'b1; end
      4'd8:  begin c.alusrca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.branch = 1'b1; end
      4'd9:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      4'd10: c.regwrite = 1'b1;
      4'd11: begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
      4'd12: begin c.alusrca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.branchne = 1'b1; end
      4'd15: c.illegal = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Entered just after a rising edge; checks at the falling edge, returns just after the next rise.
  task automatic cyc(input logic [3:0] st, input logic mr, input string tag);
    mem_ready = mr;
    @(negedge clk);
    if (memwrite === 1'b1) mw_seen++;
    chk({tag, " state"}, 32'(state), 32'(st));
    chk({tag, " ctrl"}, 32'(act), 32'(exp_ctrl(st, mr)));
    chk({tag, " instret"}, 32'(instret), 32'(exp_cnt % 16));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic mr);
    reset = 1'b1;
    mem_ready = mr;
    #1;
    exp_cnt = 0;
    chk("async reset state", 32'(state), 32'd0);
    chk("async reset ctrl", 32'(act), 32'(exp_ctrl(4'd0, mr)));
    chk("async reset instret", 32'(instret), 32'd0);
    @(posedge clk);
    #1;
    chk("held reset state", 32'(state), 32'd0);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [OPW-1:0] op;
    int             fst;
    int             mst;
    int             len;
    logic [31:0]    path;  // expected state codes, first cycle in the top nibble
    int             mw;
    string          name;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl.push_back('{op: 6'h00, fst: 0, mst: 0, len: 4, path: 32'h0167_0000, mw: 0, name: "rtype"});
    tbl.push_back('{op: 6'h23, fst: 0, mst: 3, len: 8, path: 32'h0123_3334, mw: 0, name: "lw stall3"});
    tbl.push_back('{op: 6'h2B, fst: 0, mst: 2, len: 6, path: 32'h0125_5500, mw: 3, name: "sw stall2"});
    tbl.push_back('{op: 6'h04, fst: 0, mst: 0, len: 3, path: 32'h0180_0000, mw: 0, name: "beq"});
    tbl.push_back('{op: 6'h08, fst: 0, mst: 0, len: 4, path: 32'h019A_0000, mw: 0, name: "addi"});
    tbl.push_back('{op: 6'h02, fst: 2, mst: 0, len: 5, path: 32'h0001_B000, mw: 0, name: "j fstall2"});
    tbl.push_back('{op: 6'h23, fst: 1, mst: 0, len: 6, path: 32'h0012_3400, mw: 0, name: "lw fstall1"});
    tbl.push_back('{op: 6'h2B, fst: 0, mst: 0, len: 4, path: 32'h0125_0000, mw: 1, name: "sw"});
`ifdef MAINFSM_BNE_EN
    tbl.push_back('{op: 6'h05, fst: 0, mst: 0, len: 3, path: 32'h01C0_0000, mw: 0, name: "bne"});
`endif

    // Reset held over several edges, with FETCH gating visible on both mem_ready values.
    @(posedge clk);
    #1;
    do_reset(1'b0);
    do_reset(1'b1);

    // Directed instruction table
    foreach (tbl[r]) begin
      int fs;
      int ms;
      fs = tbl[r].fst;
      ms = tbl[r].mst;
      mw_seen = 0;
      op = tbl[r].op;
      for (int i = 0; i < tbl[r].len; i++) begin
        logic [3:0] s;
        logic       mr;
        s = tbl[r].path[31-4*i -: 4];
        if (s == 4'd0 && fs > 0) begin
          mr = 1'b0;
          fs--;
        end else if ((s == 4'd3 || s == 4'd5) && ms > 0) begin
          mr = 1'b0;
          ms--;
        end else begin
          mr = 1'b1;
        end
        cyc(s, mr, tbl[r].name);
      end
      exp_cnt++;
      chk({tbl[r].name, " memwrite cycles"}, 32'(mw_seen), 32'(tbl[r].mw));
    end
    cyc(4'd0, 1'b0, "after table");

    // Unsupported opcode traps, holds for 10 cycles, and only reset clears it.
    op = 6'h3F;
    cyc(4'd0, 1'b1, "trap fetch");
    cyc(4'd1, 1'b1, "trap decode");
    repeat (10) cyc(4'd15, 1'($urandom), "trap hold");
    chk("trap illegal", 32'(illegal), 32'd1);
    do_reset(1'b1);
    chk("illegal cleared", 32'(illegal), 32'd0);

    // BNE depends on the build option.
    op = 6'h05;
    cyc(4'd0, 1'b1, "bne fetch");
    cyc(4'd1, 1'b0, "bne decode");
`ifdef MAINFSM_BNE_EN
    cyc(4'd12, 1'b0, "bne exec");
    exp_cnt++;
    cyc(4'd0, 1'b0, "bne retired");
`else
    cyc(4'd12 + 4'd3, 1'b0, "bne trap");
    chk("bne illegal", 32'(illegal), 32'd1);
`endif
    do_reset(1'b0);

    // Reset in the middle of a stalled load abandons it; the next edge runs FETCH normally.
    op = 6'h23;
    cyc(4'd0, 1'b1, "abandon fetch");
    cyc(4'd1, 1'b1, "abandon decode");
    cyc(4'd2, 1'b1, "abandon memadr");
    cyc(4'd3, 1'b0, "abandon memrd");
    cyc(4'd3, 1'b0, "abandon memrd");
    do_reset(1'b0);
    cyc(4'd0, 1'b0, "post-reset fetch stall");
    cyc(4'd0, 1'b1, "post-reset fetch");
    cyc(4'd1, 1'b1, "post-reset decode");
    cyc(4'd2, 1'b1, "post-reset memadr");
    cyc(4'd3, 1'b1, "post-reset memrd");
    cyc(4'd4, 1'b1, "post-reset memwb");
    exp_cnt++;
    cyc(4'd0, 1'b0, "post-reset retired");

    // 16 back-to-back jumps wrap the 4-bit counter to zero.
    do_reset(1'b1);
    op = 6'h02;
    repeat (16) begin
      cyc(4'd0, 1'b1, "wrap fetch");
      cyc(4'd1, 1'($urandom), "wrap decode");
      cyc(4'd11, 1'($urandom), "wrap jump");
      exp_cnt++;
    end
    chk("instret wrap", 32'(instret), 32'd0);

    // Random instruction stream against the per-opcode path model.
    for (int n = 0; n < 300; n++) begin
      logic [OPW-1:0] o;
      logic [OPW-1:0] legal [7];
      logic [OPW-1:0] bad [4];
      int             nlegal;
      int             fst;
      int             mst;
      logic           retired;
      legal = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02, 6'h05};
      bad   = '{6'h3F, 6'h01, 6'h10, 6'h1A};
`ifdef MAINFSM_BNE_EN
      nlegal = 7;
`else
      nlegal = 6;
`endif
      if ($urandom_range(0, 19) == 0) o = bad[$urandom_range(0, 3)];
      else o = legal[$urandom_range(0, nlegal - 1)];
      fst = $urandom_range(0, 2);
      mst = $urandom_range(0, 3);
      retired = 1'b1;
      op = o;
      repeat (fst) cyc(4'd0, 1'b0, "rnd fetch stall");
      cyc(4'd0, 1'b1, "rnd fetch");
      cyc(4'd1, 1'($urandom), "rnd decode");
      case (o)
        6'h00: begin
          cyc(4'd6, 1'($urandom), "rnd execute");
          cyc(4'd7, 1'($urandom), "rnd aluwb");
        end
        6'h23: begin
          cyc(4'd2, 1'($urandom), "rnd lw memadr");
          repeat (mst) cyc(4'd3, 1'b0, "rnd memrd stall");
          cyc(4'd3, 1'b1, "rnd memrd");
          cyc(4'd4, 1'($urandom), "rnd memwb");
        end
        6'h2B: begin
          cyc(4'd2, 1'($urandom), "rnd sw memadr");
          repeat (mst) cyc(4'd5, 1'b0, "rnd memwr stall");
          cyc(4'd5, 1'b1, "rnd memwr");
        end
        6'h04: cyc(4'd8, 1'($urandom), "rnd branch");
        6'h08: begin
          cyc(4'd9, 1'($urandom), "rnd addiex");
          cyc(4'd10, 1'($urandom), "rnd addiwb");
        end
        6'h02: cyc(4'd11, 1'($urandom), "rnd jump");
`ifdef MAINFSM_BNE_EN
        6'h05: cyc(4'd12, 1'($urandom), "rnd bnex");
`endif
        default: begin
          retired = 1'b0;
          repeat (3) cyc(4'd15, 1'($urandom), "rnd trap");
          do_reset(1'($urandom));
        end
      endcase
      if (retired) exp_cnt++;
    end
    cyc(4'd0, 1'b0, "final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
